// File: rtl/neighbor_partials_accumulate.sv
`default_nettype none
// ============================================================================
// Module   : neighbor_partials_accumulate
// Brief    : Merges neighbour halo partials into the output buffer (saturating RMW)
// Revision : 1.0
// ============================================================================
module neighbor_partials_accumulate #(
   parameter int BANK_COUNT = 32,
   parameter int TILE_SIZE  = 128,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [1:0]                    bitwidth,
   input  logic [DATA_WIDTH-1:0]         in_value        [8],
   input  logic [$clog2(TILE_SIZE)-1:0]  in_row          [8],
   input  logic [$clog2(TILE_SIZE)-1:0]  in_column       [8],
   input  logic [7:0]                    in_write_enable,
   output logic [7:0]                    cts,
   input  logic                          neighbors_done,
   output logic [$clog2(BANK_COUNT)-1:0] buf_read_bank,
   output logic [$clog2(TILE_SIZE)-1:0]  buf_read_entry,
   input  logic [DATA_WIDTH-1:0]         buf_read_data,
   output logic [$clog2(BANK_COUNT)-1:0] buf_write_bank,
   output logic [$clog2(TILE_SIZE)-1:0]  buf_write_entry,
   output logic [DATA_WIDTH-1:0]         buf_write_data,
   output logic                          buf_write_enable,
   output logic                          accumulate_done,
   output logic                          range_error
);
   localparam int c_ROW_W  = $clog2(TILE_SIZE);
   localparam int c_TILE_W = c_ROW_W + 1;
   localparam int c_BANK_W = $clog2(BANK_COUNT);
   localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W  = c_PTR_W + 1;
   localparam int c_ENT_W  = DATA_WIDTH + 2 * c_ROW_W;

   logic [c_ENT_W-1:0]    r_mem    [8][FIFO_DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr [8];
   logic [c_PTR_W-1:0]    r_rd_ptr [8];
   logic [c_CNT_W-1:0]    r_count  [8];
   logic [2:0]            r_rr;

   logic [c_TILE_W-1:0]   w_tile_size;
   logic [7:0]            w_nonempty;
   logic [7:0]            w_full;
   logic [7:0]            w_in_range;
   logic [7:0]            w_push;
   logic [7:0]            w_pop;
   logic                  w_any_grant;
   logic [2:0]            w_grant;
   logic [c_ENT_W-1:0]    w_head;
   logic [DATA_WIDTH-1:0] w_head_value;
   logic [c_ROW_W-1:0]    w_head_row;
   logic [c_ROW_W-1:0]    w_head_col;
   logic                  w_forward;
   logic [DATA_WIDTH-1:0] w_old;
   logic signed [DATA_WIDTH:0] w_wide;
   logic [DATA_WIDTH-1:0] w_sum;

   // Bank skew spreads consecutive rows and packed sub-rows across banks.
   function automatic logic [c_BANK_W-1:0] f_bank(input logic [c_ROW_W-1:0] row,
                                                  input logic [c_ROW_W-1:0] col,
                                                  input logic [1:0]         bw);
      logic [31:0] w_entry;
      logic [31:0] w_low;
      logic [31:0] w_total;
      w_entry = 32'(row) >> bw;
      w_low   = 32'(row) & ((32'd1 << bw) - 32'd1);
      w_total = 32'(col) + ((w_entry * 32'd3) % 32'(BANK_COUNT))
              + w_low * (32'(BANK_COUNT) >> bw);
      return c_BANK_W'(w_total % 32'(BANK_COUNT));
   endfunction

   always_comb begin
      case (bitwidth)
         2'd1:    w_tile_size = c_TILE_W'(TILE_SIZE >> 1);
         2'd2:    w_tile_size = c_TILE_W'(TILE_SIZE >> 3);
         default: w_tile_size = c_TILE_W'(TILE_SIZE);
      endcase
   end

   always_comb begin
      w_nonempty = '0;
      w_full     = '0;
      w_in_range = '0;
      w_push     = '0;
      cts        = '0;
      for (int d = 0; d < 8; d++) begin
         w_nonempty[d] = (r_count[d] != '0);
         w_full[d]     = (r_count[d] == c_CNT_W'(FIFO_DEPTH));
         w_in_range[d] = ({1'b0, in_row[d]} < w_tile_size) &&
                         ({1'b0, in_column[d]} < w_tile_size);
         w_push[d]     = in_write_enable[d] && w_in_range[d] && !w_full[d];
         cts[d]        = reset_n && (r_count[d] <= c_CNT_W'(FIFO_DEPTH - 2));
      end
   end

   // Scan downward so the lowest offset from r_rr wins.
   always_comb begin
      w_any_grant = 1'b0;
      w_grant     = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (w_nonempty[r_rr + 3'(k)]) begin
            w_any_grant = 1'b1;
            w_grant     = r_rr + 3'(k);
         end
      end
   end

   assign w_pop  = w_any_grant ? (8'd1 << w_grant) : 8'd0;
   assign w_head = r_mem[w_grant][r_rd_ptr[w_grant]];
   assign {w_head_value, w_head_row, w_head_col} = w_head;

   assign buf_read_bank  = w_any_grant ? f_bank(w_head_row, w_head_col, bitwidth) : '0;
   assign buf_read_entry = w_any_grant ? (w_head_row >> bitwidth) : '0;

   // The buffer has not yet absorbed the write in flight, so bypass it.
   assign w_forward = buf_write_enable && (buf_write_bank == buf_read_bank) &&
                      (buf_write_entry == buf_read_entry);
   assign w_old  = w_forward ? buf_write_data : buf_read_data;
   assign w_wide = $signed({w_old[DATA_WIDTH-1], w_old}) +
                   $signed({w_head_value[DATA_WIDTH-1], w_head_value});

   always_comb begin
      w_sum = w_wide[DATA_WIDTH-1:0];
      if (w_wide[DATA_WIDTH] != w_wide[DATA_WIDTH-1]) begin
         w_sum = w_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      for (int d = 0; d < 8; d++) begin
         if (w_push[d]) r_mem[d][r_wr_ptr[d]] <= {in_value[d], in_row[d], in_column[d]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int d = 0; d < 8; d++) begin
            r_wr_ptr[d] <= '0;
            r_rd_ptr[d] <= '0;
            r_count[d]  <= '0;
         end
         r_rr <= 3'd0;
      end else begin
         for (int d = 0; d < 8; d++) begin
            if (w_push[d]) r_wr_ptr[d] <= r_wr_ptr[d] + 1'b1;
            if (w_pop[d])  r_rd_ptr[d] <= r_rd_ptr[d] + 1'b1;
            if (w_push[d] && !w_pop[d])      r_count[d] <= r_count[d] + 1'b1;
            else if (!w_push[d] && w_pop[d]) r_count[d] <= r_count[d] - 1'b1;
         end
         if (w_any_grant) r_rr <= w_grant + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_write_bank   <= '0;
         buf_write_entry  <= '0;
         buf_write_data   <= '0;
         buf_write_enable <= 1'b0;
         accumulate_done  <= 1'b0;
         range_error      <= 1'b0;
      end else begin
         buf_write_enable <= w_any_grant;
         if (w_any_grant) begin
            buf_write_bank  <= buf_read_bank;
            buf_write_entry <= buf_read_entry;
            buf_write_data  <= w_sum;
         end
         if (!neighbors_done)
            accumulate_done <= 1'b0;
         else if ((w_nonempty == '0) && !buf_write_enable)
            accumulate_done <= 1'b1;
         if (|(in_write_enable & ~w_push)) range_error <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_neighbor_partials_accumulate.sv
`default_nettype none
// Directed bench for neighbor_partials_accumulate with a behavioural buffer model.
module tb_neighbor_partials_accumulate;
   localparam int BANK_COUNT = 32;
   localparam int TILE_SIZE  = 128;
   localparam int DATA_WIDTH = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int R = $clog2(TILE_SIZE);
   localparam int B = $clog2(BANK_COUNT);

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [1:0]            bitwidth;
   logic [DATA_WIDTH-1:0] in_value  [8];
   logic [R-1:0]          in_row    [8];
   logic [R-1:0]          in_column [8];
   logic [7:0]            in_write_enable;
   logic [7:0]            cts;
   logic                  neighbors_done;
   logic [B-1:0]          buf_read_bank;
   logic [R-1:0]          buf_read_entry;
   logic [DATA_WIDTH-1:0] buf_read_data;
   logic [B-1:0]          buf_write_bank;
   logic [R-1:0]          buf_write_entry;
   logic [DATA_WIDTH-1:0] buf_write_data;
   logic                  buf_write_enable;
   logic                  accumulate_done;
   logic                  range_error;

   logic [DATA_WIDTH-1:0] mem [BANK_COUNT][TILE_SIZE];
   logic                  pre_we;
   logic [B-1:0]          pre_bank;
   logic [R-1:0]          pre_entry;
   logic [DATA_WIDTH-1:0] pre_data;

   int n_cmp = 0;
   int n_err = 0;
   int exp_order [10];

   always #5 clk = ~clk;

   neighbor_partials_accumulate #(
      .BANK_COUNT(BANK_COUNT), .TILE_SIZE(TILE_SIZE),
      .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bitwidth(bitwidth),
      .in_value(in_value), .in_row(in_row), .in_column(in_column),
      .in_write_enable(in_write_enable), .cts(cts), .neighbors_done(neighbors_done),
      .buf_read_bank(buf_read_bank), .buf_read_entry(buf_read_entry),
      .buf_read_data(buf_read_data), .buf_write_bank(buf_write_bank),
      .buf_write_entry(buf_write_entry), .buf_write_data(buf_write_data),
      .buf_write_enable(buf_write_enable), .accumulate_done(accumulate_done),
      .range_error(range_error)
   );

   always @(posedge clk) begin
      if (buf_write_enable) mem[buf_write_bank][buf_write_entry] <= buf_write_data;
      else if (pre_we)      mem[pre_bank][pre_entry] <= pre_data;
   end
   assign buf_read_data = mem[buf_read_bank][buf_read_entry];

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic preload(input int b, input int e, input int d);
      pre_we = 1'b1; pre_bank = B'(b); pre_entry = R'(e); pre_data = DATA_WIDTH'(d);
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic set_push(input int d, input int v, input int r, input int c);
      in_write_enable[d] = 1'b1;
      in_value[d]  = DATA_WIDTH'(v);
      in_row[d]    = R'(r);
      in_column[d] = R'(c);
   endtask

   initial begin
      reset_n = 1'b0; bitwidth = 2'd0; neighbors_done = 1'b0; pre_we = 1'b0;
      pre_bank = '0; pre_entry = '0; pre_data = '0; in_write_enable = '0;
      for (int d = 0; d < 8; d++) begin
         in_value[d] = '0; in_row[d] = '0; in_column[d] = '0;
      end
      exp_order = '{6, 7, 0, 1, 2, 3, 4, 5, 5, 5};

      // Reset state
      cyc(1);
      chk("rst_cts", cts, 0);
      chk("rst_wen", buf_write_enable, 0);
      chk("rst_wdata", buf_write_data, 0);
      chk("rst_wbank", buf_write_bank, 0);
      chk("rst_done", accumulate_done, 0);
      chk("rst_rerr", range_error, 0);
      reset_n = 1'b1;
      cyc(1);
      chk("post_rst_cts", cts, 255);
      chk("idle_rbank", buf_read_bank, 0);

      // Single write: (5,7) bitwidth 0 maps to bank 22, entry 5
      preload(22, 5, 10);
      set_push(3, 4, 5, 7);
      cyc(1); in_write_enable = '0;
      chk("t1_rbank", buf_read_bank, 22);
      chk("t1_rentry", buf_read_entry, 5);
      cyc(1);
      chk("t1_wen", buf_write_enable, 1);
      chk("t1_wdata", $signed(buf_write_data), 14);
      chk("t1_wbank", buf_write_bank, 22);
      chk("t1_wentry", buf_write_entry, 5);
      cyc(1);
      chk("t1_wen_off", buf_write_enable, 0);
      chk("t1_mem", $signed(mem[22][5]), 14);

      // Same-address burst relies on forwarding
      preload(0, 0, 0);
      for (int d = 0; d < 3; d++) set_push(d, 1, 0, 0);
      cyc(1); in_write_enable = '0;
      chk("t2_rbank", buf_read_bank, 0);
      for (int k = 1; k <= 3; k++) begin
         cyc(1);
         chk("t2_wen", buf_write_enable, 1);
         chk("t2_wdata", $signed(buf_write_data), k);
      end
      cyc(1);
      chk("t2_wen_off", buf_write_enable, 0);
      chk("t2_mem", $signed(mem[0][0]), 3);

      // Saturation both ways: (1,0) -> bank 3 entry 1, (2,0) -> bank 6 entry 2
      preload(3, 1, 32760);
      preload(6, 2, -32760);
      set_push(3, 100, 1, 0);
      set_push(4, -100, 2, 0);
      cyc(1); in_write_enable = '0;
      chk("t3_rbank_a", buf_read_bank, 3);
      cyc(1);
      chk("t3_wbank_a", buf_write_bank, 3);
      chk("t3_sat_hi", $signed(buf_write_data), 32767);
      chk("t3_rbank_b", buf_read_bank, 6);
      cyc(1);
      chk("t3_wbank_b", buf_write_bank, 6);
      chk("t3_sat_lo", $signed(buf_write_data), -32768);
      cyc(1);

      // Backpressure: direction 5 waits behind seven busy directions
      for (int d = 0; d < 8; d++) preload(d, 0, 0);
      for (int d = 0; d < 8; d++) if (d != 5) set_push(d, d + 1, 0, d);
      for (int k = 1; k <= 11; k++) begin
         cyc(1); in_write_enable = '0;
         if (k <= 3) set_push(5, k, 0, 5);
         if (k <= 10) chk("t4_grant", buf_read_bank, exp_order[k-1]);
         if (k >= 2) begin
            chk("t4_wen", buf_write_enable, 1);
            chk("t4_wbank", buf_write_bank, exp_order[k-2]);
         end
         if (k == 3) chk("t4_cts_occ2", cts[5], 1);
         if (k == 4) chk("t4_cts_occ3", cts[5], 0);
         if (k == 8) chk("t4_cts_still", cts[5], 0);
         if (k == 9) chk("t4_cts_back", cts[5], 1);
         if (k == 11) chk("t4_dir5_sum", $signed(buf_write_data), 6);
      end
      cyc(1);
      chk("t4_idle", buf_write_enable, 0);

      // Completion with two entries queued
      chk("t6_done_pre", accumulate_done, 0);
      set_push(0, 1, 0, 0);
      set_push(1, 1, 0, 0);
      cyc(1); in_write_enable = '0; neighbors_done = 1'b1;
      chk("t6_done_busy", accumulate_done, 0);
      cyc(3);
      chk("t6_wen_last", buf_write_enable, 0);
      chk("t6_done_wait", accumulate_done, 0);
      cyc(1);
      chk("t6_done_set", accumulate_done, 1);
      neighbors_done = 1'b0;
      cyc(1);
      chk("t6_done_clr", accumulate_done, 0);

      // Bank map at other precisions, then out-of-range drops
      chk("t5_rerr_pre", range_error, 0);
      bitwidth = 2'd1;
      set_push(0, 1, 5, 7);
      cyc(1); in_write_enable = '0;
      chk("t5_bw1_bank", buf_read_bank, 29);
      chk("t5_bw1_entry", buf_read_entry, 2);
      cyc(2);
      bitwidth = 2'd2;
      set_push(0, 1, 15, 3);
      set_push(1, 1, 16, 0);
      set_push(2, 1, 0, 16);
      cyc(1); in_write_enable = '0;
      chk("t5_bw2_bank", buf_read_bank, 4);
      chk("t5_bw2_entry", buf_read_entry, 3);
      chk("t5_rerr_set", range_error, 1);
      cyc(1);
      chk("t5_wen", buf_write_enable, 1);
      chk("t5_wbank", buf_write_bank, 4);
      cyc(1);
      chk("t5_no_drop_wr", buf_write_enable, 0);
      chk("t5_no_pop", buf_read_bank, 0);
      cyc(3);
      chk("t5_rerr_sticky", range_error, 1);

      // Reset mid-operation discards the pending pop/write
      bitwidth = 2'd0;
      set_push(2, 5, 0, 2);
      cyc(1); in_write_enable = '0;
      reset_n = 1'b0;
      #1;
      chk("t7_cts_rst", cts, 0);
      chk("t7_rerr_rst", range_error, 0);
      cyc(1);
      chk("t7_wen_rst", buf_write_enable, 0);
      reset_n = 1'b1;
      cyc(1);
      chk("t7_wen_after", buf_write_enable, 0);
      chk("t7_fifo_empty", buf_read_bank, 0);
      chk("t7_cts_after", cts, 255);
      set_push(7, 1, 0, 7);
      set_push(1, 1, 0, 1);
      cyc(1); in_write_enable = '0;
      chk("t7_rr0_first", buf_read_bank, 1);
      cyc(1);
      chk("t7_rr0_second", buf_read_bank, 7);
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
